// File: rtl/wb_exmem_arbiter.sv
// wb_exmem_arbiter: shares one single-port, fixed-latency memory between the
// management Wishbone window and an accelerator master port. One access is in
// flight at a time; contention is settled round-robin on the last owner.
// Optional build macro WB_STRICT_PRIO_EN: Wishbone always wins a contest.
// All outputs are registered and cleared by the asynchronous reset.
module wb_exmem_arbiter #(
   parameter int         ADDR_W  = 10,
   parameter int         LATENCY = 2,
   parameter logic [7:0] BASE_HI = 8'h38
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic              acc_req_i,
   input  logic              acc_we_i,
   input  logic [ADDR_W-1:0] acc_adr_i,
   input  logic [31:0]       acc_dat_i,
   output logic              acc_gnt_o,
   output logic              acc_rvalid_o,
   output logic [31:0]       acc_rdata_o,
   output logic              mem_en_o,
   output logic [3:0]        mem_we_o,
   output logic [ADDR_W-1:0] mem_adr_o,
   output logic [31:0]       mem_wdat_o,
   input  logic [31:0]       mem_rdat_i
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
   typedef enum logic {OWN_WB, OWN_ACC} owner_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            last_q, last_d;
   logic              is_wr_q, is_wr_d;
   logic [3:0]        cnt_q, cnt_d;

   logic              wb_req, acc_req, wb_live, pick_acc;

   logic              wbs_ack_d, acc_gnt_d, acc_rvalid_d, mem_en_d;
   logic [31:0]       wbs_dat_d, acc_rdata_d, mem_wdat_d;
   logic [3:0]        mem_we_d;
   logic [ADDR_W-1:0] mem_adr_d;

   // Only the in-window address bits reach the memory; the rest are don't-care.
   logic unused_adr_bits;
   assign unused_adr_bits = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

   // A master still sitting in its ack cycle must not be seen as a new request.
   assign wb_req  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI) & ~wbs_ack_o;
   assign acc_req = acc_req_i;
   assign wb_live = wbs_cyc_i & wbs_stb_i;

`ifdef WB_STRICT_PRIO_EN
   assign pick_acc = acc_req & ~wb_req;
`else
   assign pick_acc = acc_req & (~wb_req | (last_q == OWN_WB));
`endif

   // State, bookkeeping and registered outputs.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_WB;
         last_q       <= OWN_ACC;
         is_wr_q      <= 1'b0;
         cnt_q        <= '0;
         wbs_ack_o    <= 1'b0;
         wbs_dat_o    <= '0;
         acc_gnt_o    <= 1'b0;
         acc_rvalid_o <= 1'b0;
         acc_rdata_o  <= '0;
         mem_en_o     <= 1'b0;
         mem_we_o     <= '0;
         mem_adr_o    <= '0;
         mem_wdat_o   <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, regardless of statement order.
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         is_wr_q      <= is_wr_d;
         cnt_q        <= cnt_d;
         wbs_ack_o    <= wbs_ack_d;
         wbs_dat_o    <= wbs_dat_d;
         acc_gnt_o    <= acc_gnt_d;
         acc_rvalid_o <= acc_rvalid_d;
         acc_rdata_o  <= acc_rdata_d;
         mem_en_o     <= mem_en_d;
         mem_we_o     <= mem_we_d;
         mem_adr_o    <= mem_adr_d;
         mem_wdat_o   <= mem_wdat_d;
      end
   end

   // Next-state and next-output logic; pulse outputs default low, data defaults to 0.
   always_comb begin
      // NOTE: every target gets a default first, so no path can infer a latch.
      state_d      = state_q;
      owner_d      = owner_q;
      last_d       = last_q;
      is_wr_d      = is_wr_q;
      cnt_d        = cnt_q;
      wbs_ack_d    = 1'b0;
      wbs_dat_d    = '0;
      acc_gnt_d    = 1'b0;
      acc_rvalid_d = 1'b0;
      acc_rdata_d  = '0;
      mem_en_d     = 1'b0;
      mem_we_d     = '0;
      mem_adr_d    = '0;
      mem_wdat_d   = '0;

      case (state_q)
         S_IDLE: begin
            if (wb_req || acc_req) begin
               state_d  = S_ISSUE;
               mem_en_d = 1'b1;
               if (pick_acc) begin
                  owner_d    = OWN_ACC;
                  is_wr_d    = acc_we_i;
                  acc_gnt_d  = 1'b1;
                  mem_adr_d  = acc_adr_i;
                  mem_we_d   = acc_we_i ? 4'hF : 4'h0;
                  mem_wdat_d = acc_dat_i;
               end else begin
                  owner_d    = OWN_WB;
                  is_wr_d    = wbs_we_i;
                  mem_adr_d  = wbs_adr_i[ADDR_W+1:2];
                  mem_we_d   = wbs_we_i ? wbs_sel_i : 4'h0;
                  mem_wdat_d = wbs_dat_i;
               end
            end
         end
         S_ISSUE: begin
            last_d  = owner_q;
            cnt_d   = 4'(LATENCY - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               // This is the cycle the memory presents data for our access.
               state_d = S_RESP;
               if (owner_q == OWN_WB) begin
                  wbs_ack_d = wb_live;
                  wbs_dat_d = (wb_live && !is_wr_q) ? mem_rdat_i : 32'h0;
               end else begin
                  acc_rvalid_d = 1'b1;
                  acc_rdata_d  = is_wr_q ? 32'h0 : mem_rdat_i;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_exmem_arbiter.sv
// Directed bench for wb_exmem_arbiter with LATENCY=2 and a behavioural
// fixed-latency memory. Inputs change and outputs are sampled on the falling edge.
module tb_wb_exmem_arbiter;

   localparam int ADDR_W = 10;
   localparam int LAT    = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]        wbs_sel_i;
   logic [31:0]       wbs_adr_i, wbs_dat_i;
   logic              wbs_ack_o;
   logic [31:0]       wbs_dat_o;
   logic              acc_req_i, acc_we_i;
   logic [ADDR_W-1:0] acc_adr_i;
   logic [31:0]       acc_dat_i;
   logic              acc_gnt_o, acc_rvalid_o;
   logic [31:0]       acc_rdata_o;
   logic              mem_en_o;
   logic [3:0]        mem_we_o;
   logic [ADDR_W-1:0] mem_adr_o;
   logic [31:0]       mem_wdat_o;
   logic [31:0]       mem_rdat_i;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] mem [1<<ADDR_W];
   logic [31:0] pipe [LAT];
   logic [31:0] model_rd;

   always #5 clk = ~clk;

   wb_exmem_arbiter #(.ADDR_W(ADDR_W), .LATENCY(LAT), .BASE_HI(8'h38)) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .wbs_cyc_i    (wbs_cyc_i),
      .wbs_stb_i    (wbs_stb_i),
      .wbs_we_i     (wbs_we_i),
      .wbs_sel_i    (wbs_sel_i),
      .wbs_adr_i    (wbs_adr_i),
      .wbs_dat_i    (wbs_dat_i),
      .wbs_ack_o    (wbs_ack_o),
      .wbs_dat_o    (wbs_dat_o),
      .acc_req_i    (acc_req_i),
      .acc_we_i     (acc_we_i),
      .acc_adr_i    (acc_adr_i),
      .acc_dat_i    (acc_dat_i),
      .acc_gnt_o    (acc_gnt_o),
      .acc_rvalid_o (acc_rvalid_o),
      .acc_rdata_o  (acc_rdata_o),
      .mem_en_o     (mem_en_o),
      .mem_we_o     (mem_we_o),
      .mem_adr_o    (mem_adr_o),
      .mem_wdat_o   (mem_wdat_o),
      .mem_rdat_i   (mem_rdat_i)
   );

   // Memory macro model: read-before-write, data appears LAT cycles after the strobe, 0 otherwise.
   always @(posedge clk) begin
      if (mem_en_o) begin
         model_rd = mem[mem_adr_o];
         for (int b = 0; b < 4; b++)
            if (mem_we_o[b]) mem[mem_adr_o][b*8 +: 8] = mem_wdat_o[b*8 +: 8];
         pipe[0] <= model_rd;
      end else begin
         pipe[0] <= 32'h0;
      end
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdat_i = pipe[LAT-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic wb_start(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
   endtask

   task automatic wb_stop();
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic acc_start(input logic [ADDR_W-1:0] adr, input logic we, input logic [31:0] dat);
      acc_req_i = 1'b1; acc_we_i = we; acc_adr_i = adr; acc_dat_i = dat;
   endtask

   initial begin
      rst = 1'b1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
      acc_req_i = 1'b0; acc_we_i = 1'b0; acc_adr_i = '0; acc_dat_i = '0;
      for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'h0;
      mem[4] = 32'hDEAD_BEEF;
      mem[2] = 32'hAAAA_BBBB;
      mem[7] = 32'hA5A5_0007;
      for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;

      // Reset values.
      tick(2);
      check("rst_ack",    32'(wbs_ack_o),    32'h0);
      check("rst_en",     32'(mem_en_o),     32'h0);
      check("rst_gnt",    32'(acc_gnt_o),    32'h0);
      check("rst_rvalid", 32'(acc_rvalid_o), 32'h0);
      rst = 1'b0;
      tick(1);

      // WB read of word 4: strobe at T+1, ack at T+4.
      wb_start(32'h3800_0010, 1'b0, 4'hF, 32'h0);
      tick(1);
      check("rd_en",       32'(mem_en_o),  32'h1);
      check("rd_adr",      32'(mem_adr_o), 32'h4);
      check("rd_we",       32'(mem_we_o),  32'h0);
      tick(1);
      check("rd_en_pulse", 32'(mem_en_o),  32'h0);
      check("rd_adr_idle", 32'(mem_adr_o), 32'h0);
      tick(1);
      check("rd_ack_early", 32'(wbs_ack_o), 32'h0);
      tick(1);
      check("rd_ack",      32'(wbs_ack_o), 32'h1);
      check("rd_dat",      wbs_dat_o,      32'hDEAD_BEEF);
      wb_stop();
      tick(1);
      check("rd_ack_pulse", 32'(wbs_ack_o), 32'h0);
      check("rd_dat_zero",  wbs_dat_o,      32'h0);

      // WB byte-masked write to word 2, then read back.
      wb_start(32'h3800_0008, 1'b1, 4'b0011, 32'h1234_5678);
      tick(1);
      check("wr_en",   32'(mem_en_o),  32'h1);
      check("wr_we",   32'(mem_we_o),  32'h3);
      check("wr_adr",  32'(mem_adr_o), 32'h2);
      check("wr_wdat", mem_wdat_o,     32'h1234_5678);
      tick(3);
      check("wr_ack",  32'(wbs_ack_o), 32'h1);
      check("wr_dat",  wbs_dat_o,      32'h0);
      wb_stop();
      tick(1);
      check("wr_ack_pulse", 32'(wbs_ack_o), 32'h0);
      wb_start(32'h3800_0008, 1'b0, 4'hF, 32'h0);
      tick(4);
      check("wr_rb_ack", 32'(wbs_ack_o), 32'h1);
      check("wr_rb_dat", wbs_dat_o,      32'hAAAA_5678);
      wb_stop();
      tick(1);

      // Out-of-window Wishbone access is ignored.
      wb_start(32'h3900_0010, 1'b0, 4'hF, 32'h0);
      tick(1);
      check("oow_en",  32'(mem_en_o),  32'h0);
      tick(3);
      check("oow_ack", 32'(wbs_ack_o), 32'h0);
      wb_stop();
      tick(1);

      // ACC read of word 7.
      acc_start(10'd7, 1'b0, 32'h0);
      tick(1);
      check("acc_gnt",   32'(acc_gnt_o), 32'h1);
      check("acc_en",    32'(mem_en_o),  32'h1);
      check("acc_adr",   32'(mem_adr_o), 32'h7);
      acc_req_i = 1'b0;
      tick(1);
      check("acc_gnt_pulse", 32'(acc_gnt_o), 32'h0);
      tick(2);
      check("acc_rvalid", 32'(acc_rvalid_o), 32'h1);
      check("acc_rdata",  acc_rdata_o,       32'hA5A5_0007);
      tick(1);
      check("acc_rvalid_pulse", 32'(acc_rvalid_o), 32'h0);
      check("acc_rdata_zero",   acc_rdata_o,       32'h0);

      // ACC full-word write to word 9.
      acc_start(10'd9, 1'b1, 32'h0BAD_F00D);
      tick(1);
      check("accw_we",   32'(mem_we_o), 32'hF);
      check("accw_wdat", mem_wdat_o,    32'h0BAD_F00D);
      acc_req_i = 1'b0;
      tick(3);
      check("accw_rvalid", 32'(acc_rvalid_o), 32'h1);
      check("accw_rdata",  acc_rdata_o,       32'h0);
      check("accw_mem",    mem[9],            32'h0BAD_F00D);
      tick(1);

      // Fresh reset, then both requesters held: WB, ACC, WB, ACC.
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      wb_start(32'h3800_0010, 1'b0, 4'hF, 32'h0);
      acc_start(10'd7, 1'b0, 32'h0);
      tick(1);
      check("rr1_en",  32'(mem_en_o),  32'h1);
      check("rr1_adr", 32'(mem_adr_o), 32'h4);
      check("rr1_gnt", 32'(acc_gnt_o), 32'h0);
      tick(3);
      check("rr1_ack", 32'(wbs_ack_o), 32'h1);
      check("rr1_dat", wbs_dat_o,      32'hDEAD_BEEF);
      tick(2);
      check("rr2_gnt", 32'(acc_gnt_o), 32'h1);
      check("rr2_adr", 32'(mem_adr_o), 32'h7);
      tick(3);
      check("rr2_rvalid", 32'(acc_rvalid_o), 32'h1);
      check("rr2_rdata",  acc_rdata_o,       32'hA5A5_0007);
      tick(2);
      check("rr3_en",  32'(mem_en_o),  32'h1);
      check("rr3_adr", 32'(mem_adr_o), 32'h4);
      check("rr3_gnt", 32'(acc_gnt_o), 32'h0);
      tick(5);
      check("rr4_gnt", 32'(acc_gnt_o), 32'h1);
      check("rr4_adr", 32'(mem_adr_o), 32'h7);
      wb_stop();
      acc_req_i = 1'b0;
      tick(4);

      // WB read aborted during WAIT: no ack, next ACC request served normally.
      wb_start(32'h3800_0010, 1'b0, 4'hF, 32'h0);
      tick(2);
      wb_stop();
      tick(2);
      check("abt_ack", 32'(wbs_ack_o), 32'h0);
      check("abt_dat", wbs_dat_o,      32'h0);
      acc_start(10'd7, 1'b0, 32'h0);
      tick(2);
      check("abt_acc_gnt", 32'(acc_gnt_o), 32'h1);
      check("abt_acc_adr", 32'(mem_adr_o), 32'h7);
      acc_req_i = 1'b0;
      tick(3);
      check("abt_acc_rvalid", 32'(acc_rvalid_o), 32'h1);
      check("abt_acc_rdata",  acc_rdata_o,       32'hA5A5_0007);
      tick(1);

      // Reset during WAIT of a WB read; the first contest afterwards still goes to WB.
      wb_start(32'h3800_0010, 1'b0, 4'hF, 32'h0);
      tick(2);
      #2 rst = 1'b1;
      #1;
      check("rstw_en",     32'(mem_en_o),     32'h0);
      check("rstw_ack",    32'(wbs_ack_o),    32'h0);
      check("rstw_rvalid", 32'(acc_rvalid_o), 32'h0);
      wb_stop();
      tick(2);
      rst = 1'b0;
      tick(3);
      check("rstw_no_ack",    32'(wbs_ack_o),    32'h0);
      check("rstw_no_rvalid", 32'(acc_rvalid_o), 32'h0);
      wb_start(32'h3800_0010, 1'b0, 4'hF, 32'h0);
      acc_start(10'd7, 1'b0, 32'h0);
      tick(1);
      check("rstw_first_en",  32'(mem_en_o),  32'h1);
      check("rstw_first_adr", 32'(mem_adr_o), 32'h4);
      check("rstw_first_gnt", 32'(acc_gnt_o), 32'h0);

      // Reset mid-ISSUE clears the strobe before the next clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_async_en",  32'(mem_en_o),  32'h0);
      check("rst_async_adr", 32'(mem_adr_o), 32'h0);
      wb_stop();
      acc_req_i = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
